// File: rtl/deserializer.sv
// Serial-to-parallel receiver: collects LENGTH bits LSB first, framed by a
// start-of-frame strobe, and presents each completed word with a valid pulse.
module deserializer #(
    parameter int LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sof,
    input  logic              i_din,
    output logic [LENGTH-1:0] ov_dout,
    output logic              o_dout_valid,
    output logic              o_busy,
    output logic              o_err
);

    localparam int CW = $clog2(LENGTH);
    localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [LENGTH-1:0] sreg, sreg_nx, dout_nx;
    logic              valid_nx, err_nx, busy_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sreg         <= '0;
            ov_dout      <= '0;
            o_dout_valid <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            sreg         <= sreg_nx;
            ov_dout      <= dout_nx;
            o_dout_valid <= valid_nx;
            o_err        <= err_nx;
            o_busy       <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sreg_nx  = sreg;
        dout_nx  = ov_dout;
        valid_nx = 1'b0;
        err_nx   = 1'b0;

        if (i_en) begin
            if (i_sof) begin
                // A strobe always opens a fresh frame; inside SHIFT it aborts the old one.
                err_nx     = (state == SHIFT);
                sreg_nx    = '0;
                sreg_nx[0] = i_din;
                cnt_nx     = CW'(1);
                state_nx   = SHIFT;
            end else if (state == SHIFT) begin
                sreg_nx[cnt] = i_din;
                cnt_nx       = cnt + CW'(1);
                if (cnt == LAST) begin
                    // Upper bits were cleared at frame start, so sreg_nx is the whole word.
                    dout_nx  = sreg_nx;
                    valid_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
        end

        busy_nx = (state_nx == SHIFT);
    end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed frame scenarios plus random
// traffic, every cycle compared against a bit-collecting reference model.
module tb_deserializer;

    localparam int LEN = 24;

    logic           clk = 1'b0;
    logic           rst, en, sof, din;
    logic [LEN-1:0] dout;
    logic           valid, busy, err;

    always #5 clk = ~clk;

    deserializer #(.LENGTH(LEN)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sof       (sof),
        .i_din       (din),
        .ov_dout     (dout),
        .o_dout_valid(valid),
        .o_busy      (busy),
        .o_err       (err)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Reference model state
    bit             m_in;
    int             m_n;
    logic [LEN-1:0] m_word, m_dout;
    logic           m_valid, m_err, m_busy;

    // Per-scenario observations
    int             valid_cnt, err_cnt, busy_cnt, err_cyc;
    int             valid_cyc[$];
    logic [LEN-1:0] valid_word[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int vc(input int idx);
        return (valid_cyc.size() > idx) ? valid_cyc[idx] : -1000;
    endfunction

    function automatic logic [63:0] vw(input int idx);
        return (valid_word.size() > idx) ? 64'(valid_word[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic clear_stats();
        valid_cnt = 0;
        err_cnt   = 0;
        busy_cnt  = 0;
        err_cyc   = -1000;
        valid_cyc.delete();
        valid_word.delete();
    endtask

    task automatic step(input logic r, input logic e, input logic s, input logic d);
        rst = r; en = e; sof = s; din = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_in = 0; m_n = 0; m_word = '0; m_dout = '0; m_valid = 0; m_err = 0;
        end else begin
            m_valid = 0;
            m_err   = 0;
            if (e) begin
                if (s) begin
                    m_err  = m_in;
                    m_in   = 1;
                    m_word = LEN'(d);
                    m_n    = 1;
                end else if (m_in) begin
                    m_word = m_word | (LEN'(d) << m_n);
                    m_n++;
                    if (m_n == LEN) begin
                        m_dout  = m_word;
                        m_valid = 1;
                        m_in    = 0;
                    end
                end
            end
        end
        m_busy = m_in;
        #1;
        chk("dout",  dout,  m_dout);
        chk("valid", valid, m_valid);
        chk("busy",  busy,  m_busy);
        chk("err",   err,   m_err);
        if (valid) begin
            valid_cnt++;
            valid_cyc.push_back(cyc);
            valid_word.push_back(dout);
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (busy) busy_cnt++;
    endtask

    // Sends the low nbits of w; stall_len idle (en=0) cycles follow bits sa and sb.
    task automatic send(input logic [LEN-1:0] w, input int nbits, input int sa, input int sb,
                        input int stall_len, output int start);
        start = -1;
        for (int i = 0; i < nbits; i++) begin
            step(1'b0, 1'b1, (i == 0), w[i]);
            if (i == 0) start = cyc;
            if (i == sa || i == sb)
                for (int k = 0; k < stall_len; k++)
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int s1, s2;
        m_in = 0; m_n = 0; m_word = '0; m_dout = '0; m_valid = 0; m_err = 0; m_busy = 0;
        rst = 1'b1; en = 1'b0; sof = 1'b0; din = 1'b0;
        clear_stats();

        // Reset, including reset winning over a start-of-frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("reset_dout", dout, 0);
        chk("reset_busy", busy, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 1: contiguous frame
        clear_stats();
        send(24'hA5C3F1, 24, -1, -1, 0, s1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid_cnt", valid_cnt, 1);
        chk("t1_word", vw(0), 24'hA5C3F1);
        chk("t1_latency", vc(0) - s1, 23);
        chk("t1_busy_cycles", busy_cnt, 23);
        chk("t1_dout_hold", dout, 24'hA5C3F1);

        // 2: stalls after bits 5 and 17
        clear_stats();
        send(24'h123456, 24, 5, 17, 3, s1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t2_valid_cnt", valid_cnt, 1);
        chk("t2_word", vw(0), 24'h123456);
        chk("t2_latency", vc(0) - s1, 29);

        // 3: early abort after 10 bits
        clear_stats();
        send(24'hFFFFFF, 10, -1, -1, 0, s1);
        send(24'h00000F, 24, -1, -1, 0, s2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_err_cnt", err_cnt, 1);
        chk("t3_err_cycle", err_cyc, s2);
        chk("t3_valid_cnt", valid_cnt, 1);
        chk("t3_word", vw(0), 24'h00000F);
        chk("t3_latency", vc(0) - s2, 23);

        // 4: back-to-back frames
        clear_stats();
        send(24'hDEADBE, 24, -1, -1, 0, s1);
        send(24'h0BEEF0, 24, -1, -1, 0, s2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_valid_cnt", valid_cnt, 2);
        chk("t4_word0", vw(0), 24'hDEADBE);
        chk("t4_word1", vw(1), 24'h0BEEF0);
        chk("t4_spacing", vc(1) - vc(0), 24);
        chk("t4_err_cnt", err_cnt, 0);

        // 5: reset mid-frame, then a clean frame
        clear_stats();
        send(24'hCAFE12, 12, -1, -1, 0, s1);
        step(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("t5_dout_zero", dout, 0);
        chk("t5_busy_zero", busy, 0);
        chk("t5_no_valid", valid_cnt, 0);
        chk("t5_no_err", err_cnt, 0);
        send(24'h5A5A5A, 24, -1, -1, 0, s1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_word", vw(0), 24'h5A5A5A);

        // 6: data without start-of-frame is ignored
        clear_stats();
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
        chk("t6_busy", busy_cnt, 0);
        chk("t6_valid", valid_cnt, 0);
        chk("t6_err", err_cnt, 0);
        chk("t6_dout", dout, 24'h5A5A5A);

        // 7: early start-of-frame on the last bit slot
        clear_stats();
        send(24'hABCDEF, 23, -1, -1, 0, s1);
        send(24'h13579B, 24, -1, -1, 0, s2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t7_err_cnt", err_cnt, 1);
        chk("t7_valid_cnt", valid_cnt, 1);
        chk("t7_word", vw(0), 24'h13579B);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++)
            step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
